// File: rtl/scr1_sleep_ctrl.sv
// WFI sleep sequencer: drains the pipe, requests clock gating, wakes on irq/debug and settles before releasing WFI.
// Defining SCR1_SLEEP_CNT_EN adds a saturating count of cycles spent in SLEEP on o_sleep_cnt.
module scr1_sleep_ctrl #(
  parameter int DRAIN_TMO = 16,
  parameter int WAKE_DLY  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wfi_req,
  input  logic        i_pipe_idle,
  input  logic        i_irq_pending,
  input  logic        i_dbg_req,
  input  logic        i_clk_pipe_en,
  output logic        o_sleep_pipe,
  output logic        o_wake_pipe,
  output logic        o_wfi_done,
  output logic        o_sleeping,
  output logic [31:0] o_sleep_cnt
);

  if (DRAIN_TMO < 1 || DRAIN_TMO > 255 || WAKE_DLY < 0 || WAKE_DLY > 15) begin : g_bad_cfg
    $error("scr1_sleep_ctrl: DRAIN_TMO must be 1..255 and WAKE_DLY 0..15");
  end

  localparam logic [7:0] TMO_LAST = 8'(DRAIN_TMO - 1);
  localparam logic [3:0] DLY_LAST = 4'(WAKE_DLY - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_SLP_REQ,
    ST_SLEEP,
    ST_WAKE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_tmo_cnt;
  logic [3:0]  r_dly_cnt;
  logic        r_post_done;
  logic        w_wake_ev;

  assign w_wake_ev = i_irq_pending | i_dbg_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_tmo_cnt   <= 8'd0;
      r_dly_cnt   <= 4'd0;
      r_post_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // Counters only run while their state is held; any other state keeps them cleared for the next entry.
      r_tmo_cnt   <= (r_state == ST_DRAIN)  ? r_tmo_cnt + 8'd1 : 8'd0;
      r_dly_cnt   <= (r_state == ST_SETTLE) ? r_dly_cnt + 4'd1 : 4'd0;
      r_post_done <= (r_state == ST_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        // A WFI still held high right after the done pulse must not start a second sequence.
        if (i_wfi_req && !r_post_done) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!i_wfi_req)                 w_state_nxt = ST_RUN;
        else if (w_wake_ev)             w_state_nxt = ST_DONE;
        else if (i_pipe_idle)           w_state_nxt = ST_SLP_REQ;
        else if (r_tmo_cnt == TMO_LAST) w_state_nxt = ST_DONE;
      end
      ST_SLP_REQ: begin
        if (w_wake_ev)           w_state_nxt = ST_WAKE;
        else if (!i_clk_pipe_en) w_state_nxt = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (w_wake_ev) w_state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (i_clk_pipe_en) begin
          if (WAKE_DLY == 0) w_state_nxt = ST_DONE;
          else               w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_dly_cnt == DLY_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs decode the state register only, so sleep_pipe and wake_pipe are mutually exclusive.
  always_comb begin
    o_sleep_pipe = (r_state == ST_SLP_REQ);
    o_wake_pipe  = (r_state == ST_WAKE);
    o_wfi_done   = (r_state == ST_DONE);
    o_sleeping   = (r_state == ST_SLEEP);
  end

`ifdef SCR1_SLEEP_CNT_EN
  logic [31:0] r_sleep_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sleep_cnt <= 32'd0;
    end else if (r_state == ST_SLEEP && r_sleep_cnt != 32'hFFFF_FFFF) begin
      r_sleep_cnt <= r_sleep_cnt + 32'd1;
    end
  end

  assign o_sleep_cnt = r_sleep_cnt;
`else
  assign o_sleep_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_scr1_sleep_ctrl.sv
// Self-checking bench for scr1_sleep_ctrl: randomized WFI episodes checked against a timeline model.
// Expected output waveforms are derived from the event times of each episode with plain arithmetic.
module tb_scr1_sleep_ctrl;

  localparam int DRAIN_TMO = 16;
  localparam int WAKE_DLY  = 2;
`ifdef SCR1_SLEEP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wfi_req, pipe_idle, irq_pending, dbg_req, clk_pipe_en;
  logic        sleep_pipe, wake_pipe, wfi_done, sleeping;
  logic [31:0] sleep_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  scr1_sleep_ctrl #(.DRAIN_TMO(DRAIN_TMO), .WAKE_DLY(WAKE_DLY)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wfi_req    (wfi_req),
    .i_pipe_idle  (pipe_idle),
    .i_irq_pending(irq_pending),
    .i_dbg_req    (dbg_req),
    .i_clk_pipe_en(clk_pipe_en),
    .o_sleep_pipe (sleep_pipe),
    .o_wake_pipe  (wake_pipe),
    .o_wfi_done   (wfi_done),
    .o_sleeping   (sleeping),
    .o_sleep_cnt  (sleep_cnt)
  );

  wire [3:0] obs = {sleep_pipe, wake_pipe, wfi_done, sleeping};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wfi_req = 1'b0; pipe_idle = 1'b0; irq_pending = 1'b0;
    dbg_req = 1'b0; clk_pipe_en = 1'b1;
    @(negedge clk);
    tick(); tick(); tick();
    n_chk++;
    if (obs !== 4'b0000) begin
      n_fail++; $display("FAIL reset_out obs=%b exp=0000", obs);
    end
    n_chk++;
    if (sleep_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt got=%0d exp=0", sleep_cnt);
    end
    rst = 1'b0;
    tick(); tick();
    n_chk++;
    if (obs !== 4'b0000) begin
      n_fail++; $display("FAIL post_reset_out obs=%b exp=0000", obs);
    end
    m_cnt = 0;
  endtask

  // Full sleep/wake episode; vector order is {sleep_pipe, wake_pipe, wfi_done, sleeping}.
  task automatic test_sleep_wake(input int iters);
    for (int it = 0; it < iters; it++) begin
      int d, a, l, b, s, g, w, r, dn, base, src;
      if (it == 0) begin
        d = 0; a = 0; l = 99; b = 0; src = 0;
      end else begin
        d = $urandom_range(10); a = $urandom_range(3); l = $urandom_range(20);
        b = $urandom_range(3); src = $urandom_range(1);
      end
      s  = (d + 1 < 2) ? 2 : d + 1;
      g  = s + a;
      w  = g + 1 + l;
      r  = w + 1 + b;
      dn = r + WAKE_DLY + 1;
      base = m_cnt;
      for (int t = 0; t <= dn + 3; t++) begin
        logic [3:0]  exp_v;
        logic [31:0] exp_c;
        int sl;
        exp_v = {(t >= s && t <= g), (t >= w + 1 && t <= r), (t == dn), (t >= g + 1 && t <= w)};
        sl = ((t < w + 1) ? t : w + 1) - (g + 1);
        if (sl < 0) sl = 0;
        exp_c = CNT_EN ? 32'(base + sl) : 32'd0;
        n_chk++;
        if (obs !== exp_v) begin
          n_fail++; $display("FAIL sleep_wake_out it=%0d t=%0d obs=%b exp=%b", it, t, obs, exp_v);
        end
        n_chk++;
        if (sleep_cnt !== exp_c) begin
          n_fail++; $display("FAIL sleep_wake_cnt it=%0d t=%0d got=%0d exp=%0d", it, t, sleep_cnt, exp_c);
        end
        wfi_req     = (t <= dn);
        pipe_idle   = (t >= d);
        clk_pipe_en = !(t >= g && t < r);
        irq_pending = (t >= w && t <= dn) && (src == 0);
        dbg_req     = (t >= w && t <= dn) && (src == 1);
        tick();
      end
      m_cnt = m_cnt + (w - g);
    end
  endtask

  // Idle never arrives, or arrives one cycle too late: abort on timeout after DRAIN_TMO drain cycles.
  task automatic test_drain_timeout();
    int idle_at [2] = '{1000, DRAIN_TMO + 1};
    for (int c = 0; c < 2; c++) begin
      for (int t = 0; t <= DRAIN_TMO + 4; t++) begin
        logic [3:0] exp_v;
        exp_v = {1'b0, 1'b0, (t == DRAIN_TMO + 1), 1'b0};
        n_chk++;
        if (obs !== exp_v) begin
          n_fail++; $display("FAIL drain_tmo case=%0d t=%0d obs=%b exp=%b", c, t, obs, exp_v);
        end
        wfi_req = (t <= DRAIN_TMO + 1); pipe_idle = (t >= idle_at[c]);
        irq_pending = 1'b0; dbg_req = 1'b0; clk_pipe_en = 1'b1;
        tick();
      end
    end
  endtask

  // Wake event while draining aborts entry, even when pipe_idle rises in the same cycle.
  task automatic test_wake_in_drain(input int iters);
    for (int it = 0; it < iters; it++) begin
      int k, both, src;
      k    = (it == 0) ? 3 : $urandom_range(DRAIN_TMO - 1, 1);
      both = (it == 1) ? 1 : $urandom_range(1);
      src  = $urandom_range(1);
      for (int t = 0; t <= k + 4; t++) begin
        logic [3:0] exp_v;
        exp_v = {1'b0, 1'b0, (t == k + 1), 1'b0};
        n_chk++;
        if (obs !== exp_v) begin
          n_fail++; $display("FAIL wake_in_drain it=%0d t=%0d obs=%b exp=%b", it, t, obs, exp_v);
        end
        wfi_req     = (t <= k + 1);
        pipe_idle   = (both == 1) && (t >= k);
        irq_pending = (t >= k && t <= k + 1) && (src == 0);
        dbg_req     = (t >= k && t <= k + 1) && (src == 1);
        clk_pipe_en = 1'b1;
        tick();
      end
    end
  endtask

  // Wake arrives while sleep_pipe is up and the clock is still running.
  task automatic test_race(input int iters);
    for (int it = 0; it < iters; it++) begin
      int d, x, s, r, dn, src;
      d   = (it == 0) ? DRAIN_TMO : $urandom_range(10);
      x   = $urandom_range(3);
      src = (it == 0) ? 1 : $urandom_range(1);
      s   = (d + 1 < 2) ? 2 : d + 1;
      r   = s + x + 1;
      dn  = r + WAKE_DLY + 1;
      for (int t = 0; t <= dn + 3; t++) begin
        logic [3:0] exp_v;
        exp_v = {(t >= s && t <= s + x), (t == r), (t == dn), 1'b0};
        n_chk++;
        if (obs !== exp_v) begin
          n_fail++; $display("FAIL race it=%0d t=%0d obs=%b exp=%b", it, t, obs, exp_v);
        end
        wfi_req     = (t <= dn);
        pipe_idle   = (t >= d);
        irq_pending = (t >= s + x && t <= dn) && (src == 0);
        dbg_req     = (t >= s + x && t <= dn) && (src == 1);
        clk_pipe_en = 1'b1;
        tick();
      end
    end
  endtask

  // WFI withdrawn during drain: silent return, later idle must not start a sleep.
  task automatic test_wfi_abort();
    int j;
    j = $urandom_range(10, 2);
    for (int t = 0; t <= j + DRAIN_TMO + 3; t++) begin
      n_chk++;
      if (obs !== 4'b0000) begin
        n_fail++; $display("FAIL wfi_abort j=%0d t=%0d obs=%b exp=0000", j, t, obs);
      end
      wfi_req = (t < j); pipe_idle = (t >= j + 1);
      irq_pending = 1'b0; dbg_req = 1'b0; clk_pipe_en = 1'b1;
      tick();
    end
  endtask

  // wfi_req held across a done pulse re-enters only after the guard cycle.
  task automatic test_back_to_back();
    int dn2;
    dn2 = 8 + WAKE_DLY;
    for (int t = 0; t <= dn2 + 3; t++) begin
      logic [3:0] exp_v;
      exp_v = {(t == 6), (t == 7), (t == 2 || t == dn2), 1'b0};
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL back_to_back t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
      wfi_req = (t <= dn2); pipe_idle = (t >= 2);
      dbg_req = (t < 2) || (t >= 6 && t <= dn2);
      irq_pending = 1'b0; clk_pipe_en = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset_mid_sleep();
    for (int t = 0; t <= 6; t++) begin
      logic [3:0] exp_v;
      exp_v = {(t == 2), 1'b0, 1'b0, (t >= 3 && t <= 5)};
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL reset_mid_sleep t=%0d obs=%b exp=%b", t, obs, exp_v);
      end
      rst = (t == 5); wfi_req = (t < 5); pipe_idle = 1'b1;
      irq_pending = 1'b0; dbg_req = 1'b0; clk_pipe_en = (t < 2) || (t >= 5);
      if (t < 6) tick();
    end
    n_chk++;
    if (sleep_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_sleep_cnt got=%0d exp=0", sleep_cnt);
    end
    rst = 1'b0;
    m_cnt = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sleep_wake(6);
    test_drain_timeout();
    test_wake_in_drain(5);
    test_race(4);
    test_wfi_abort();
    test_back_to_back();
    test_reset_mid_sleep();
    test_sleep_wake(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scr1_sleep_ctrl.md
Name: scr1_sleep_ctrl

Overview:
Sequences entry to and exit from pipeline clock-gated sleep on WFI. It drives the sleep_pipe/wake_pipe request pair of the core clock controller and observes the resulting clk_pipe_en. It waits for the pipeline to drain before requesting sleep, wakes on interrupt or debug request, and enforces a settle delay before the pipeline resumes. The block runs on the always-on clock next to the clock controller.

Parameters:
DRAIN_TMO, 16, max cycles to wait for pipe_idle before aborting sleep entry (1..255).
WAKE_DLY, 2, cycles after clk_pipe_en rises before wfi_done is issued (0..15).

Ports:
clk  in  1  always-on core clock
rst  in  1  synchronous reset, active-high
wfi_req  in  1  level; pipeline is stalled on a WFI instruction
pipe_idle  in  1  no outstanding fetch or LSU transactions
irq_pending  in  1  enabled interrupt pending (level)
dbg_req  in  1  debug halt/wake request (level)
clk_pipe_en  in  1  pipeline clock enable status from the clock controller
sleep_pipe  out  1  sleep request to the clock controller
wake_pipe  out  1  wake request to the clock controller
wfi_done  out  1  one-cycle pulse; pipeline may retire the WFI
sleeping  out  1  status: pipeline clock is gated
sleep_cnt  out  32  cycles spent in SLEEP (feature only; 0 when absent)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=RUN; sleep_pipe=0, wake_pipe=0, wfi_done=0, sleeping=0, sleep_cnt=0, and all counters are cleared. Reset asserted in any state returns the block to RUN on the next edge with no wfi_done pulse.
- Outputs are registered: each is a function of the current state or a registered flag, and no input reaches an output combinationally.
- Define wake_ev = irq_pending | dbg_req.
- States and transitions:
  - RUN: when wfi_req=1 and wfi_done=0, go to DRAIN and clear tmo_cnt.
  - DRAIN:
    - If wake_ev=1, go to DONE without sleeping. wake_ev has priority over pipe_idle.
    - Else if pipe_idle=1, go to SLP_REQ.
    - Else increment tmo_cnt. When tmo_cnt==DRAIN_TMO-1, go to DONE (timeout abort).
    - If wfi_req drops, return to RUN with no pulse.
  - SLP_REQ: sleep_pipe=1. When clk_pipe_en=0 is observed, go to SLEEP. If wake_ev=1 arrives first, go to WAKE. In that case sleep_pipe and wake_pipe are never both 1 in the same cycle; sleep_pipe drops first.
  - SLEEP: sleeping=1 and sleep_pipe=0. When wake_ev=1, go to WAKE.
  - WAKE: wake_pipe=1, held until clk_pipe_en=1 is observed. Then clear dly_cnt and go to SETTLE. If WAKE_DLY=0, go directly to DONE.
  - SETTLE: increment dly_cnt. When dly_cnt==WAKE_DLY-1, go to DONE.
  - DONE: wfi_done=1 for exactly one cycle, then go to RUN.
- RUN ignores wfi_req in the cycle that follows a wfi_done pulse, so a still-high wfi_req cannot re-trigger.
- Latency:
  - wfi_req to sleep_pipe, pipeline already idle: 2 cycles.
  - wake_ev to wake_pipe in SLEEP: 1 cycle.
  - clk_pipe_en rise to wfi_done: WAKE_DLY+1 cycles.
- wfi_req is sampled only in RUN and DRAIN. A wake_ev pulse shorter than 1 cycle is not supported; levels are required.
- Counter widths: tmo_cnt is 8 bits and dly_cnt is 4 bits. Parameters outside their stated range are a static configuration error.

Optional Feature:
Macro SCR1_SLEEP_CNT_EN.
- With the macro: sleep_cnt increments by 1 for every cycle spent in SLEEP, saturates at 32'hFFFF_FFFF, and is cleared only by rst.
- Without the macro: sleep_cnt is tied to 0 and no counter flops are instantiated.

Test Plan:
1. Basic sleep/wake, defaults. wfi_req=1 with pipe_idle=1 -> sleep_pipe at cycle 2. Drop clk_pipe_en -> sleeping=1. irq_pending=1 -> wake_pipe next cycle. Raise clk_pipe_en -> wfi_done exactly 3 cycles later.
2. Drain timeout. wfi_req=1 with pipe_idle held 0 -> no sleep_pipe; wfi_done after 16 DRAIN cycles.
3. Wake during drain. wfi_req=1 with pipe_idle=0, irq_pending=1 at cycle 3 -> DONE; wfi_done pulse with sleep_pipe never asserted.
4. Race in SLP_REQ. dbg_req=1 while sleep_pipe=1 and clk_pipe_en still 1 -> wake_pipe next cycle; sleep_pipe/wake_pipe never both 1; wfi_done issued.
5. Reset mid-sleep. Assert rst in SLEEP -> next cycle all outputs 0 and state RUN; re-entry works normally.
6. With SCR1_SLEEP_CNT_EN, 100 cycles in SLEEP -> sleep_cnt=100. Build without the macro -> sleep_cnt=0.
